uart_command_issuer: RTL and testbench
======================================

# uart_command_issuer

Host-side initiator for the single-byte LED command protocol. It encodes SET/TOGGLE/NOP requests into command bytes and sends them through the UART transmitter handshake. It then waits for the one-byte reply from the remote command decoder, with a timeout and bounded retry, and classifies the reply. It sits between local control logic (buttons/test sequencer) and the UART TX/RX pair, and keeps a shadow of the remote BGR colour.

## Interface
- TIMEOUT_CYCLES, 1200000: reply timeout in clk cycles, counted from entry to RESP_WAIT; must be ≥2.
- MAX_RETRIES, 2: resends after a timeout before reporting TIMEOUT; 0 allowed.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  request strobe
- cmd_op  in  2  00 NOP, 01 SET, 10 TOGGLE, 11 RAW-invalid
- cmd_arg  in  3  {b,g,r} colour / toggle mask
- cmd_ready  out  1  high only in IDLE
- snd_data  out  8  byte to UART TX
- snd_ready  out  1  TX request
- snd_busy  in  1  UART TX busy
- rcv_data  in  8  byte from UART RX, valid with rcv_ready
- rcv_ready  in  1  one-cycle received-byte strobe
- done  out  1  one-cycle result pulse
- status  out  2  00 OK, 01 MISMATCH, 10 DECODE_ERR, 11 TIMEOUT; held until next done
- resp_byte  out  8  last reply byte; 0 on timeout
- shadow_color  out  3  believed remote {b,g,r}
- shadow_valid  out  1  shadow_color trustworthy
- stray_flag  out  1  sticky: byte received outside RESP_WAIT

## Operation
- Encoding, latched at accept:
  - NOP → 0x20
  - SET → {5'b10000, arg}
  - TOGGLE → {5'b01000, arg}
  - RAW → {5'b11000, arg}, an intentionally invalid byte.
- Expected colour, computed at accept:
  - SET → arg
  - TOGGLE → shadow_color ^ arg
  - NOP → shadow_color
  - RAW → none.
  - Checking is enabled for SET always, and for TOGGLE/NOP only if shadow_valid. RAW is never checked.
- Reply classification:
  - rcv_data[7:3] == 5'b11111 → DECODE_ERR; shadow unchanged.
  - rcv_data[7:3] == 5'b00000 → colour reply. shadow_color ← rcv_data[2:0], shadow_valid ← 1. Status is MISMATCH if checking is enabled and the colour ≠ expected, otherwise OK.
  - Any other prefix → DECODE_ERR.
- FSM:
  - IDLE: cmd_ready=1. cmd_valid → latch byte/expected, retry_cnt←0, go SEND.
  - SEND: when snd_busy==0, drive snd_data and snd_ready=1, go SEND_WAIT.
  - SEND_WAIT: hold snd_ready/snd_data until snd_busy==1, then snd_ready←0, clear timer, go RESP_WAIT.
  - RESP_WAIT: rcv_ready → classify, go DONE. If the timer reaches TIMEOUT_CYCLES-1 with no byte: resend (retry_cnt+1, go SEND) if retry_cnt < MAX_RETRIES; otherwise status TIMEOUT, resp_byte←0, shadow_valid←0, go DONE.
  - DONE: done=1 for one cycle, then go IDLE.
- A rcv_ready in any state other than RESP_WAIT sets stray_flag; the byte is discarded.
- Reset values:
  - state IDLE; cmd_ready 1 (from first cycle after reset).
  - snd_data 0, snd_ready 0.
  - done 0, status 00, resp_byte 0.
  - shadow_color 3'b001 (remote resets to red), shadow_valid 0, stray_flag 0.
  - Timer and retry_cnt 0.
- Reset mid-transaction aborts immediately. snd_ready drops the next edge; no done is issued.

## Timing
- Accept edge → SEND the next cycle. snd_ready rises one cycle after entering SEND if snd_busy is low, so the earliest snd_ready is 2 cycles after cmd_valid.
- snd_ready stays high for at least one cycle and until snd_busy is sampled high.
- A reply received on cycle N in RESP_WAIT gives done on cycle N+1. status/resp_byte/shadow are updated on the same edge that enters DONE.
- A timeout occurs exactly TIMEOUT_CYCLES cycles after entering RESP_WAIT.
- If rcv_ready coincides with the timeout cycle, the reply wins.
- Total worst case without a reply is (MAX_RETRIES+1) timeouts.
- cmd_valid outside IDLE is ignored; there is no queuing.
- The timer is wide enough for TIMEOUT_CYCLES; it does not wrap.

## Test plan
- Reset, then SET arg=3'b100 → snd_data 0x84. Reply 0x04 → status OK, shadow 100, valid 1.
- After the shadow is 100, TOGGLE arg=3'b101 → 0x45 sent, expected 001. Reply 0x01 → OK. Reply 0x03 instead → MISMATCH, shadow 011.
- RAW arg=3'b000 → 0xC0 sent. Reply 0xFA → DECODE_ERR, resp_byte 0xFA, shadow unchanged.
- No reply, MAX_RETRIES=2, TIMEOUT_CYCLES=16 → three sends 16 cycles apart, then TIMEOUT, resp_byte 0, shadow_valid 0.
- snd_busy held high for 10 cycles in SEND → snd_ready stays 0 until busy falls. A rcv_ready pulse in IDLE → stray_flag 1 and no done.
- Reset asserted in RESP_WAIT → next cycle IDLE, snd_ready 0, no done, shadow 001/valid 0.

Source files
------------

// File: rtl/uart_command_issuer.sv
// Host-side initiator for the single-byte LED command protocol: encodes a request,
// hands it to the UART TX, waits for the reply with timeout/retry and classifies it.
module uart_command_issuer #(
   parameter int unsigned TIMEOUT_CYCLES = 1200000,
   parameter int unsigned MAX_RETRIES    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_op,
   input  logic [2:0] cmd_arg,
   output logic       cmd_ready,
   output logic [7:0] snd_data,
   output logic       snd_ready,
   input  logic       snd_busy,
   input  logic [7:0] rcv_data,
   input  logic       rcv_ready,
   output logic       done,
   output logic [1:0] status,
   output logic [7:0] resp_byte,
   output logic [2:0] shadow_color,
   output logic       shadow_valid,
   output logic       stray_flag
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {S_IDLE, S_SEND, S_SEND_WAIT, S_RESP_WAIT, S_DONE} state_t;
   typedef enum logic [1:0] {OP_NOP, OP_SET, OP_TOGGLE, OP_RAW} op_t;
   typedef enum logic [1:0] {ST_OK, ST_MISMATCH, ST_DECODE_ERR, ST_TIMEOUT} status_t;

   state_t        state, state_nxt;
   status_t       status_r;
   op_t           op;
   logic [TW-1:0] timer;
   logic [RW-1:0] retry_cnt;
   logic [7:0]    cmd_byte;
   logic [7:0]    enc_byte;
   logic [2:0]    exp_color, exp_nxt;
   logic          chk_en, chk_nxt;
   logic          accept, got_reply, expired, retry;

   assign op        = op_t'(cmd_op);
   assign accept    = (state == S_IDLE) && cmd_valid;
   assign got_reply = (state == S_RESP_WAIT) && rcv_ready;
   // A reply arriving on the final timer cycle takes priority over the timeout.
   assign expired   = (state == S_RESP_WAIT) && !rcv_ready && (timer == T_LAST);
   assign retry     = expired && (retry_cnt < R_MAX);

   assign snd_data  = cmd_byte;
   assign status    = status_r;

   always_comb begin
      enc_byte = 8'h20;
      exp_nxt  = shadow_color;
      chk_nxt  = shadow_valid;
      case (op)
         OP_NOP:    begin enc_byte = 8'h20; exp_nxt = shadow_color; end
         OP_SET:    begin enc_byte = {5'b10000, cmd_arg}; exp_nxt = cmd_arg; chk_nxt = 1'b1; end
         OP_TOGGLE: begin enc_byte = {5'b01000, cmd_arg}; exp_nxt = shadow_color ^ cmd_arg; end
         OP_RAW:    begin enc_byte = {5'b11000, cmd_arg}; chk_nxt = 1'b0; end
         default:   ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (cmd_valid) state_nxt = S_SEND;
         S_SEND:      if (!snd_busy) state_nxt = S_SEND_WAIT;
         S_SEND_WAIT: if (snd_busy) state_nxt = S_RESP_WAIT;
         S_RESP_WAIT: begin
            if (got_reply)    state_nxt = S_DONE;
            else if (retry)   state_nxt = S_SEND;
            else if (expired) state_nxt = S_DONE;
         end
         S_DONE:      state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (state == S_IDLE);
      snd_ready = (state == S_SEND_WAIT);
      done      = (state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer        <= '0;
         retry_cnt    <= '0;
         cmd_byte     <= '0;
         exp_color    <= '0;
         chk_en       <= 1'b0;
         status_r     <= ST_OK;
         resp_byte    <= '0;
         shadow_color <= 3'b001;
         shadow_valid <= 1'b0;
         stray_flag   <= 1'b0;
      end else begin
         if (accept) begin
            cmd_byte  <= enc_byte;
            exp_color <= exp_nxt;
            chk_en    <= chk_nxt;
            retry_cnt <= '0;
         end
         if (state == S_SEND_WAIT && snd_busy) timer <= '0;
         else if (state == S_RESP_WAIT)        timer <= timer + TW'(1);
         if (retry) retry_cnt <= retry_cnt + RW'(1);
         if (got_reply) begin
            resp_byte <= rcv_data;
            if (rcv_data[7:3] == 5'b00000) begin
               shadow_color <= rcv_data[2:0];
               shadow_valid <= 1'b1;
               status_r     <= (chk_en && rcv_data[2:0] != exp_color) ? ST_MISMATCH : ST_OK;
            end else begin
               status_r <= ST_DECODE_ERR;
            end
         end else if (expired && !retry) begin
            status_r     <= ST_TIMEOUT;
            resp_byte    <= '0;
            shadow_valid <= 1'b0;
         end
         if (rcv_ready && state != S_RESP_WAIT) stray_flag <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_command_issuer.sv
// Scoreboard bench for uart_command_issuer: expected sends and results are queued
// by the stimulus and popped by independent monitors.
module tb_uart_command_issuer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b00;
   logic [2:0] cmd_arg = 3'b000;
   logic       cmd_ready;
   logic [7:0] snd_data;
   logic       snd_ready;
   logic       snd_busy;
   logic [7:0] rcv_data = 8'h00;
   logic       rcv_ready = 1'b0;
   logic       done;
   logic [1:0] status;
   logic [7:0] resp_byte;
   logic [2:0] shadow_color;
   logic       shadow_valid;
   logic       stray_flag;

   logic        resp_busy = 1'b0;
   logic        hold_busy = 1'b0;
   logic        prev_rdy = 1'b0;
   int unsigned cyc = 0;
   int          passed = 0;
   int          total = 0;
   logic [7:0]  send_q[$];
   logic [13:0] res_q[$];

   localparam logic [1:0] NOP = 2'b00, SET = 2'b01, TOG = 2'b10, RAW = 2'b11;

   assign snd_busy = resp_busy | hold_busy;

   uart_command_issuer #(.TIMEOUT_CYCLES(16), .MAX_RETRIES(2)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
      .cmd_ready(cmd_ready), .snd_data(snd_data), .snd_ready(snd_ready), .snd_busy(snd_busy),
      .rcv_data(rcv_data), .rcv_ready(rcv_ready), .done(done), .status(status),
      .resp_byte(resp_byte), .shadow_color(shadow_color), .shadow_valid(shadow_valid),
      .stray_flag(stray_flag)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // UART TX model: acknowledges a request by going busy for one cycle.
   always @(negedge clk) resp_busy <= snd_ready;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (snd_ready && !prev_rdy) begin
         if (send_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_send: got 0x%0h, required no send", snd_data);
         end else check("snd_data", {24'h0, snd_data}, {24'h0, send_q.pop_front()});
      end
      prev_rdy <= snd_ready;
   end

   always @(negedge clk) begin
      if (done) begin
         if (res_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_done: got status %0d, required no done", status);
         end else check("result", {18'h0, status, resp_byte, shadow_color, shadow_valid},
                        {18'h0, res_q.pop_front()});
      end
   end

   task automatic expect_res(input logic [1:0] st, input logic [7:0] rb,
                             input logic [2:0] sc, input logic sv);
      res_q.push_back({st, rb, sc, sv});
   endtask

   task automatic issue(input logic [1:0] op, input logic [2:0] arg,
                        input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) send_q.push_back(b);
      @(negedge clk);
      check("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_send(output int unsigned rise, output int unsigned fall);
      int k;
      k = 0;
      while (!snd_ready && k < 200) begin @(negedge clk); k++; end
      if (!snd_ready) begin total++; $display("FAIL send_wait: got no snd_ready, required one"); end
      rise = cyc;
      k = 0;
      while (snd_ready && k < 50) begin @(negedge clk); k++; end
      if (snd_ready) begin total++; $display("FAIL send_release: got snd_ready stuck, required drop"); end
      fall = cyc;
   endtask

   task automatic reply(input logic [7:0] b, input int delay);
      repeat (delay) @(negedge clk);
      rcv_data = b; rcv_ready = 1'b1;
      @(negedge clk);
      rcv_ready = 1'b0;
      check("done_latency", {31'h0, done}, 32'h1);
   endtask

   task automatic txn(input logic [1:0] op, input logic [2:0] arg, input logic [7:0] b,
                      input logic [7:0] rb, input int delay,
                      input logic [1:0] st, input logic [2:0] sc, input logic sv);
      int unsigned r, f;
      expect_res(st, rb, sc, sv);
      issue(op, arg, b, 1);
      wait_send(r, f);
      reply(rb, delay);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned r0, f0, r1, f1, r2, f2;
      int k;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      check("rst_snd", {23'h0, snd_ready, snd_data}, 32'h0);
      check("rst_result", {21'h0, done, status, resp_byte}, 32'h0);
      check("rst_shadow", {28'h0, shadow_color, shadow_valid}, 32'h2);
      check("rst_stray", {31'h0, stray_flag}, 32'h0);
      reset = 1'b0;

      txn(SET, 3'b100, 8'h84, 8'h04, 3, 2'b00, 3'b100, 1'b1);
      txn(TOG, 3'b101, 8'h45, 8'h03, 2, 2'b01, 3'b011, 1'b1);
      txn(TOG, 3'b101, 8'h45, 8'h06, 5, 2'b00, 3'b110, 1'b1);
      txn(RAW, 3'b000, 8'hC0, 8'hFA, 1, 2'b10, 3'b110, 1'b1);
      txn(NOP, 3'b000, 8'h20, 8'hF8, 0, 2'b10, 3'b110, 1'b1);
      txn(NOP, 3'b000, 8'h20, 8'h06, 4, 2'b00, 3'b110, 1'b1);
      txn(NOP, 3'b000, 8'h20, 8'h07, 4, 2'b01, 3'b111, 1'b1);

      expect_res(2'b11, 8'h00, 3'b111, 1'b0);
      issue(SET, 3'b010, 8'h82, 3);
      wait_send(r0, f0);
      wait_send(r1, f1);
      check("retry_gap1", r1 - f0, 32'd17);
      wait_send(r2, f2);
      check("retry_gap2", r2 - f1, 32'd17);
      k = 0;
      while (!done && k < 40) begin @(negedge clk); k++; end
      check("timeout_latency", cyc - f2, 32'd16);
      @(negedge clk);

      txn(TOG, 3'b001, 8'h41, 8'h05, 2, 2'b00, 3'b101, 1'b1);
      txn(SET, 3'b011, 8'h83, 8'h03, 15, 2'b00, 3'b011, 1'b1);

      expect_res(2'b00, 8'h03, 3'b011, 1'b1);
      hold_busy = 1'b1;
      issue(NOP, 3'b000, 8'h20, 1);
      check("cmd_ready_busy", {31'h0, cmd_ready}, 32'h0);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin cmd_valid = 1'b1; cmd_op = SET; cmd_arg = 3'b111; end
         if (i == 4) cmd_valid = 1'b0;
         @(negedge clk);
         check("snd_ready_held", {31'h0, snd_ready}, 32'h0);
      end
      hold_busy = 1'b0;
      wait_send(r0, f0);
      reply(8'h03, 2);
      @(negedge clk);

      rcv_data = 8'h04; rcv_ready = 1'b1;
      @(negedge clk);
      rcv_ready = 1'b0;
      check("stray_set", {31'h0, stray_flag}, 32'h1);
      check("stray_idle", {31'h0, cmd_ready}, 32'h1);
      check("status_held", {22'h0, status, resp_byte}, {22'h0, 2'b00, 8'h03});
      repeat (5) @(negedge clk);

      issue(SET, 3'b111, 8'h87, 1);
      wait_send(r0, f0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_idle", {30'h0, cmd_ready, snd_ready}, 32'h2);
      check("abort_result", {21'h0, done, status, resp_byte}, 32'h0);
      check("abort_shadow", {27'h0, shadow_color, shadow_valid, stray_flag}, 32'h4);
      repeat (30) @(negedge clk);

      check("send_q_empty", send_q.size(), 32'd0);
      check("res_q_empty", res_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
